sim_uart_boot: RTL and testbench

Simulation top-level boot block: receives a length-prefixed program image over a UART line and stores it into an internal word-addressed instruction memory. Once the last byte has arrived, it reports completion back over the UART transmit line. It sits between the host serial link (`rxd`/`txd`) and the core's instruction store, and is the first thing exercised after reset.

---
 rtl/sim_uart_boot.sv | 181 ++++++++++++++++++
 tb/tb_sim_uart_boot.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_uart_boot.sv
// Simulation boot loader: receives a length-prefixed image over UART into imem,
// then reports 0xAA followed by the 8-bit image checksum on txd.
module sim_uart_boot #(
    parameter int CLKS_PER_BIT = 5,
    parameter int IMEM_WORDS   = 1024
) (
    input  logic sys_clock,
    input  logic reset,
    input  logic rxd,
    output logic txd
);
    localparam int          AW        = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] WORDS     = 32'(IMEM_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {LD_HDR, LD_LOAD, LD_REPORT, LD_DONE} ld_state_e;

    logic [31:0] imem [IMEM_WORDS];

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q, rx_byte_q;
    logic        rx_valid_q;

    ld_state_e   ld_state_q;
    logic [1:0]  hdr_idx_q;
    logic [31:0] length_q, count_q;
    logic [7:0]  csum_q;

    logic        tx_q;
    logic [15:0] tx_cnt_q;
    logic [4:0]  tx_left_q;
    logic [19:0] tx_shift_q;

    logic [31:0]   length_d;
    logic [7:0]    csum_d;
    logic [7:0]    tx_sum;
    logic          tx_start;
    logic          mem_we;
    logic [AW-1:0] mem_word;
    logic [1:0]    mem_lane;

    always_comb begin
        length_d = length_q;
        length_d[8*hdr_idx_q +: 8] = rx_byte_q;
        csum_d   = csum_q + rx_byte_q;
        tx_sum   = (ld_state_q == LD_HDR) ? 8'h00 : csum_d;
        tx_start = rx_valid_q &&
                   (((ld_state_q == LD_HDR) && (hdr_idx_q == 2'd3) && (length_d == 32'd0)) ||
                    ((ld_state_q == LD_LOAD) && (count_q == length_q - 32'd1)));
        // Bytes past the end of imem are still counted and summed, just not stored.
        mem_we   = !reset && rx_valid_q && (ld_state_q == LD_LOAD) &&
                   ({2'b00, count_q[31:2]} < WORDS);
        mem_word = count_q[AW+1:2];
        mem_lane = count_q[1:0];
    end

    always_ff @(posedge sys_clock) begin
        if (mem_we) begin
            imem[mem_word][8*mem_lane +: 8] <= rx_byte_q;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            ld_state_q <= LD_HDR;
            hdr_idx_q  <= '0;
            length_q   <= '0;
            count_q    <= '0;
            csum_q     <= '0;
            tx_q       <= 1'b1;
            tx_cnt_q   <= '0;
            tx_left_q  <= '0;
            tx_shift_q <= '1;
        end else begin
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_valid_q <= 1'b0;

            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rx_s2_q) begin
                            rx_valid_q <= 1'b1;
                            rx_byte_q  <= rx_shift_q;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase

            case (ld_state_q)
                LD_HDR: begin
                    count_q <= '0;
                    csum_q  <= '0;
                    if (rx_valid_q) begin
                        length_q  <= length_d;
                        hdr_idx_q <= hdr_idx_q + 2'd1;
                        if (hdr_idx_q == 2'd3) begin
                            ld_state_q <= (length_d == 32'd0) ? LD_REPORT : LD_LOAD;
                        end
                    end
                end
                LD_LOAD: begin
                    if (rx_valid_q) begin
                        count_q <= count_q + 32'd1;
                        csum_q  <= csum_d;
                        if (count_q == length_q - 32'd1) ld_state_q <= LD_REPORT;
                    end
                end
                LD_REPORT: begin
                    if (tx_left_q == 5'd0) ld_state_q <= LD_DONE;
                end
                default: ;
            endcase

            // Both report frames go out as one 20-bit shift; the top pad bit holds idle after the last stop.
            if (tx_start) begin
                tx_q       <= 1'b0;
                tx_shift_q <= {2'b11, tx_sum, 1'b0, 1'b1, 8'hAA};
                tx_left_q  <= 5'd20;
                tx_cnt_q   <= '0;
            end else if (tx_left_q != 5'd0) begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_q   <= '0;
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[19:1]};
                    tx_left_q  <= tx_left_q - 5'd1;
                end else begin
                    tx_cnt_q <= tx_cnt_q + 16'd1;
                end
            end
        end
    end

    assign txd = tx_q;

endmodule

// File: tb/tb_sim_uart_boot.sv
// Bench for sim_uart_boot: drives UART images, decodes txd, and compares imem
// and the report against a byte-level model of the load.
module tb_sim_uart_boot;
    localparam int CPB   = 5;
    localparam int WORDS = 64;

    logic sys_clock = 1'b0;
    logic reset     = 1'b1;
    logic rxd       = 1'b1;
    logic txd;

    sim_uart_boot #(.CLKS_PER_BIT(CPB), .IMEM_WORDS(WORDS)) dut (
        .sys_clock(sys_clock),
        .reset    (reset),
        .rxd      (rxd),
        .txd      (txd)
    );

    always #5 sys_clock = ~sys_clock;

    int unsigned cyc = 0;
    always @(posedge sys_clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_mem   [WORDS];
    logic [3:0]  exp_known [WORDS];
    logic [7:0]  img[$];

    logic [7:0]  tx_bytes[$];
    int unsigned tx_starts[$];
    bit          tx_frame_ok[$];
    bit          mon_en = 1'b0;
    int unsigned last_stop_cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Independent UART decoder on txd, sampling mid-bit.
    initial begin : tx_monitor
        logic [7:0]  b;
        int unsigned t0;
        bit          ok;
        wait (mon_en);
        forever begin
            @(negedge sys_clock);
            if (txd === 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                repeat (CPB / 2) @(negedge sys_clock);
                if (txd !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge sys_clock);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge sys_clock);
                if (txd !== 1'b1) ok = 1'b0;
                tx_bytes.push_back(b);
                tx_starts.push_back(t0);
                tx_frame_ok.push_back(ok);
            end
        end
    end

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge sys_clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        last_stop_cyc = cyc;
        send_bit(good_stop);
        if (!good_stop) begin
            send_bit(1'b1);
            send_bit(1'b1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (2) @(negedge sys_clock);
        reset = 1'b0;
        tx_bytes.delete();
        tx_starts.delete();
        tx_frame_ok.delete();
    endtask

    // Reference: byte i of the image lands in word i/4, lane i%4, if that word exists.
    task automatic model_load(input int n);
        for (int i = 0; i < n; i++) begin
            if (i / 4 < WORDS) begin
                exp_mem[i/4][8*(i%4) +: 8] = img[i];
                exp_known[i/4][i%4] = 1'b1;
            end
        end
    endtask

    function automatic logic [7:0] model_sum();
        int s = 0;
        foreach (img[i]) s += int'(img[i]);
        return 8'(s % 256);
    endfunction

    task automatic check_mem(input string tag);
        for (int w = 0; w < WORDS; w++) begin
            if (exp_known[w] == 4'hF) check_val($sformatf("%s_imem%0d", tag, w), dut.imem[w], exp_mem[w]);
        end
    endtask

    task automatic expect_report(input string tag, input logic [7:0] sum);
        int unsigned waited = 0;
        int unsigned lat;
        while (tx_bytes.size() < 2 && waited < 30 * CPB + 200) begin
            @(negedge sys_clock);
            waited++;
        end
        check_val($sformatf("%s_txcount", tag), tx_bytes.size(), 2);
        if (tx_bytes.size() >= 2) begin
            check_val($sformatf("%s_tx0", tag), {24'd0, tx_bytes[0]}, 32'h0000_00AA);
            check_val($sformatf("%s_tx1", tag), {24'd0, tx_bytes[1]}, {24'd0, sum});
            check_val($sformatf("%s_frames", tag), {31'd0, tx_frame_ok[0] & tx_frame_ok[1]}, 32'd1);
            check_val($sformatf("%s_gap", tag), tx_starts[1] - tx_starts[0], 10 * CPB);
            lat = tx_starts[0] - last_stop_cyc;
            check_val($sformatf("%s_latency%0d", tag, lat),
                      {31'd0, (lat >= CPB / 2 + 1) && (lat <= CPB + 4)}, 32'd1);
        end
        repeat (12 * CPB) @(negedge sys_clock);
        check_val($sformatf("%s_txidle", tag), {31'd0, txd}, 32'd1);
        check_val($sformatf("%s_txfinal", tag), tx_bytes.size(), 2);
    endtask

    task automatic load_image(input logic [31:0] len, input string tag);
        for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8]);
        foreach (img[i]) send_byte(img[i]);
        expect_report(tag, model_sum());
        model_load(img.size());
        check_mem(tag);
    endtask

    task automatic rand_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin : main
        int bad;
        int len;
        for (int w = 0; w < WORDS; w++) exp_known[w] = 4'h0;
        @(negedge sys_clock);
        do_reset();
        mon_en = 1'b1;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clock);
            if (txd !== 1'b1) bad++;
        end
        check_val("reset_hold_txd", bad, 0);
        check_val("reset_hold_frames", tx_bytes.size(), 0);
        check_val("reset_length", dut.length_q, 0);
        check_val("reset_count", dut.count_q, 0);
        check_val("reset_csum", {24'd0, dut.csum_q}, 0);

        img = {8'h01, 8'h02, 8'h03, 8'h04};
        load_image(32'd4, "small");
        check_val("small_word0", dut.imem[0], 32'h0403_0201);

        do_reset();
        img.delete();
        img = {8'h15, 8'h00, 8'h40, 8'h00};
        for (int i = 0; i < 160; i++) img.push_back(8'($urandom_range(0, 255)));
        img.push_back(8'h0E); img.push_back(8'hC8); img.push_back(8'hFF); img.push_back(8'h37);
        load_image(32'd168, "full");
        check_val("full_word0", dut.imem[0], 32'h0040_0015);
        check_val("full_word41", dut.imem[41], 32'h37FF_C80E);

        do_reset();
        img.delete();
        load_image(32'd0, "empty");
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
        repeat (4 * CPB) @(negedge sys_clock);
        check_val("empty_ignored_tx", tx_bytes.size(), 2);
        check_mem("empty_ignored");

        do_reset();
        rxd = 1'b0;
        @(negedge sys_clock);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge sys_clock);
        rand_img(4);
        load_image(32'd4, "glitch");

        do_reset();
        rand_img(4);
        send_byte(8'h04);
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        for (int k = 0; k < 3; k++) send_byte(8'h00);
        foreach (img[i]) send_byte(img[i]);
        expect_report("framing", model_sum());
        check_val("framing_length", dut.length_q, 32'd4);
        model_load(4);
        check_mem("framing");

        do_reset();
        for (int k = 0; k < 4; k++) send_byte(k == 0 ? 8'h04 : 8'h00);
        rand_img(2);
        foreach (img[i]) send_byte(img[i]);
        repeat (3 * CPB) @(negedge sys_clock);
        check_val("midload_no_tx", tx_bytes.size(), 0);
        model_load(2);
        do_reset();
        check_val("midload_count", dut.count_q, 0);
        check_val("midload_csum", {24'd0, dut.csum_q}, 0);
        img = {8'h01, 8'h02, 8'h03, 8'h04};
        load_image(32'd4, "reload");
        check_val("reload_word0", dut.imem[0], 32'h0403_0201);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            len = $urandom_range(1, 23);
            rand_img(len);
            load_image(32'(len), $sformatf("rand%0d", r));
        end

        do_reset();
        rand_img(WORDS * 4 + 3);
        load_image(32'(WORDS * 4 + 3), "overflow");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
